// File: rtl/eth_udp_rx.sv
// eth_udp_rx: GMII receive-side UDP deframer (125 MHz domain).
// Strips preamble/SFD, Ethernet, IPv4 and UDP headers and filters on the
// local MAC (or broadcast), IP and port. Streams the UDP payload out with
// sof/eof strobes two cycles after the byte appears on rxd, then reports a
// per-frame done/ok pulse.
// Optional macro ETH_RX_FCS_CHECK_EN adds a CRC-32 residue check on the FCS.
module eth_udp_rx #(
  parameter logic [47:0] LOCAL_MAC  = 48'h0011_2233_4455,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_010A,
  parameter logic [15:0] LOCAL_PORT = 16'd5000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_125,
  input  logic             reset_n,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  input  logic             rx_er,
  output logic [7:0]       pl_data,
  output logic             pl_valid,
  output logic             pl_sof,
  output logic             pl_eof,
  output logic [31:0]      src_ip,
  output logic [15:0]      src_port,
  output logic             frm_done,
  output logic             frm_ok,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ETH, S_IP, S_UDP, S_PAY, S_WAIT, S_DRAIN
  } state_t;

  state_t      state, nxt;
  logic [7:0]  d_q;
  logic        dv_q, er_q;
  logic [4:0]  cnt;
  logic        mac_ok, bc_ok, er_seen, sof_pend;
  logic [7:0]  len_hi;
  logic [15:0] udp_len, rem;
  logic [31:0] sh_ip;
  logic [15:0] sh_port;

  // comb control strobes
  logic       cnt_clr, sfd, emit, eof_c, done_c, ok_c, drop_inc, good_inc;
  logic       mac_run, bc_run, fcs_ok;
  logic [7:0] mac_sel, ip_sel, port_sel;

  // expected header bytes selected by the running byte counter
  assign mac_sel  = 8'(LOCAL_MAC >> {3'd5 - cnt[2:0], 3'b000});
  assign ip_sel   = 8'(LOCAL_IP >> {2'd3 - cnt[1:0], 3'b000});
  assign port_sel = cnt[0] ? LOCAL_PORT[7:0] : LOCAL_PORT[15:8];
  assign mac_run  = (cnt == 5'd0 || mac_ok) && (d_q == mac_sel);
  assign bc_run   = (cnt == 5'd0 || bc_ok) && (d_q == 8'hFF);

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0] crc, crc_nxt, crc_rev;

  // reflected CRC-32, one byte per cycle
  always_comb begin
    crc_nxt = crc ^ {24'h0, d_q};
    for (int i = 0; i < 8; i++)
      crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ 32'hEDB88320) : (crc_nxt >> 1);
    for (int i = 0; i < 32; i++)
      crc_rev[i] = crc[31-i];
  end

  assign fcs_ok = (crc_rev == 32'hC704DD7B);

  // CRC runs from first MAC byte through last FCS byte
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n)
      crc <= 32'hFFFF_FFFF;
    else if (sfd)
      crc <= 32'hFFFF_FFFF;
    else if (dv_q && (state == S_ETH || state == S_IP || state == S_UDP ||
                      state == S_PAY || state == S_WAIT))
      crc <= crc_nxt;
  end
`else
  assign fcs_ok = 1'b1;
`endif

  // input register stage
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      d_q  <= '0;
      dv_q <= 1'b0;
      er_q <= 1'b0;
    end else begin
      d_q  <= rxd;
      dv_q <= rx_dv;
      er_q <= rx_er;
    end
  end

  // state register
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // next-state and per-cycle strobes
  always_comb begin
    nxt      = state;
    cnt_clr  = 1'b0;
    sfd      = 1'b0;
    emit     = 1'b0;
    eof_c    = 1'b0;
    done_c   = 1'b0;
    ok_c     = 1'b0;
    drop_inc = 1'b0;
    good_inc = 1'b0;
    case (state)
      S_IDLE, S_PRE: begin
        // IDLE treats its first valid byte as preamble so no byte is lost
        if (!dv_q)               nxt = S_IDLE;
        else if (d_q == 8'h55)   nxt = S_PRE;
        else if (d_q == 8'hD5) begin
          nxt = S_ETH; cnt_clr = 1'b1; sfd = 1'b1;
        end else                 nxt = S_DRAIN;
      end
      S_ETH: begin
        if (!dv_q) begin
          nxt = S_IDLE; drop_inc = 1'b1;
        end else if ((cnt == 5'd5 && !(mac_run || bc_run)) ||
                     (cnt == 5'd12 && d_q != 8'h08) ||
                     (cnt == 5'd13 && d_q != 8'h00)) begin
          nxt = S_DRAIN; drop_inc = 1'b1;
        end else if (cnt == 5'd13) begin
          nxt = S_IP; cnt_clr = 1'b1;
        end
      end
      S_IP: begin
        if (!dv_q) begin
          nxt = S_IDLE; drop_inc = 1'b1;
        end else if ((cnt == 5'd0 && d_q != 8'h45) ||
                     (cnt == 5'd9 && d_q != 8'h11) ||
                     (cnt >= 5'd16 && d_q != ip_sel)) begin
          nxt = S_DRAIN; drop_inc = 1'b1;
        end else if (cnt == 5'd19) begin
          nxt = S_UDP; cnt_clr = 1'b1;
        end
      end
      S_UDP: begin
        if (!dv_q) begin
          nxt = S_IDLE; drop_inc = 1'b1;
        end else if (((cnt == 5'd2 || cnt == 5'd3) && d_q != port_sel) ||
                     (cnt == 5'd5 && {len_hi, d_q} < 16'd8)) begin
          nxt = S_DRAIN; drop_inc = 1'b1;
        end else if (cnt == 5'd7) begin
          nxt = (udp_len == 16'd8) ? S_WAIT : S_PAY;
        end
      end
      S_PAY: begin
        if (!dv_q) begin
          // truncated payload: report a bad frame
          nxt = S_IDLE; done_c = 1'b1; drop_inc = 1'b1;
        end else begin
          emit = 1'b1;
          if (rem == 16'd1) begin
            eof_c = 1'b1; nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!dv_q) begin
          nxt    = S_IDLE;
          done_c = 1'b1;
          ok_c   = !er_seen && fcs_ok;
          good_inc = ok_c;
          drop_inc = !ok_c;
        end
      end
      S_DRAIN: begin
        if (!dv_q) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // header tracking: byte counter, match flags, shadows, payload length
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      mac_ok   <= 1'b0;
      bc_ok    <= 1'b0;
      er_seen  <= 1'b0;
      sof_pend <= 1'b0;
      len_hi   <= '0;
      udp_len  <= '0;
      rem      <= '0;
      sh_ip    <= '0;
      sh_port  <= '0;
    end else begin
      cnt <= cnt_clr ? 5'd0 : cnt + 5'd1;
      if (sfd)                 er_seen <= 1'b0;
      else if (dv_q && er_q)   er_seen <= 1'b1;
      if (state == S_ETH && cnt < 5'd6) begin
        mac_ok <= mac_run;
        bc_ok  <= bc_run;
      end
      if (state == S_IP && cnt >= 5'd12 && cnt <= 5'd15)
        sh_ip <= {sh_ip[23:0], d_q};
      if (state == S_UDP) begin
        if (cnt <= 5'd1) sh_port <= {sh_port[7:0], d_q};
        if (cnt == 5'd4) len_hi  <= d_q;
        if (cnt == 5'd5) udp_len <= {len_hi, d_q};
        if (cnt == 5'd7) begin
          rem      <= udp_len - 16'd8;
          sof_pend <= 1'b1;
        end
      end
      if (emit) begin
        rem      <= rem - 16'd1;
        sof_pend <= 1'b0;
      end
    end
  end

  // registered outputs, counters and committed sender identity
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      pl_data  <= '0;
      pl_valid <= 1'b0;
      pl_sof   <= 1'b0;
      pl_eof   <= 1'b0;
      frm_done <= 1'b0;
      frm_ok   <= 1'b0;
      src_ip   <= '0;
      src_port <= '0;
      frm_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      pl_data  <= emit ? d_q : 8'h00;
      pl_valid <= emit;
      pl_sof   <= emit && sof_pend;
      pl_eof   <= eof_c;
      frm_done <= done_c;
      frm_ok   <= done_c && ok_c;
      if (good_inc) begin
        src_ip   <= sh_ip;
        src_port <= sh_port;
        if (frm_cnt != '1) frm_cnt <= frm_cnt + 1'b1;
      end
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: doc/eth_udp_rx.md
Name: eth_udp_rx

Overview:
- GMII receive-side UDP deframer for the 1G Ethernet path; counterpart of the UDP transmit path in eth_1g_top.
- Sits between the PHY GMII RX pins (125 MHz domain) and the command/control logic.
- Strips preamble/SFD, Ethernet, IPv4 and UDP headers. Filters on local MAC (or broadcast), IP and UDP port.
- Streams UDP payload bytes out with framing strobes, then reports per-frame status.

Parameters:
- LOCAL_MAC, 48'h0011_2233_4455, accepted destination MAC (FF..FF broadcast also accepted)
- LOCAL_IP, 32'hC0A8_010A, accepted destination IPv4 address (192.168.1.10)
- LOCAL_PORT, 16'd5000, accepted UDP destination port
- CNT_W, 16, width of the frame/drop counters

Ports:
- clk_125  in  1  GMII RX clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- rxd  in  8  GMII receive data
- rx_dv  in  1  GMII data valid
- rx_er  in  1  GMII receive error
- pl_data  out  8  payload byte
- pl_valid  out  1  pl_data valid
- pl_sof  out  1  first payload byte of frame (with pl_valid)
- pl_eof  out  1  last payload byte per UDP length (with pl_valid)
- src_ip  out  32  sender IP of last accepted frame
- src_port  out  16  sender UDP port of last accepted frame
- frm_done  out  1  one-cycle pulse at end of every frame that reached PAYLOAD
- frm_ok  out  1  qualifies frm_done: 1 = frame good
- frm_cnt  out  CNT_W  count of frm_done with frm_ok=1, saturating
- drop_cnt  out  CNT_W  count of rejected or bad frames, saturating

Behaviour:
- Reset: all outputs 0, state IDLE. reset_n is asynchronous assert, usable mid-frame; the partial frame is lost and nothing is signalled.
- Inputs are registered once. pl_* for the rxd byte at cycle N is valid at cycle N+2; fixed latency, no backpressure.
- State IDLE: wait for rx_dv=1.
- State PRE: accept 0x55 bytes. On 0xD5 go to ETH and clear byte counter. Any other byte goes to DRAIN.
- State ETH, 14 bytes:
  - bytes 0-5 must equal LOCAL_MAC or all-FF;
  - bytes 12-13 must be 0x0800;
  - on mismatch go to DRAIN and increment drop_cnt.
- State IP, 20 bytes:
  - byte 0 must be 0x45 (no options);
  - byte 9 must be 0x11;
  - bytes 16-19 must equal LOCAL_IP;
  - bytes 12-15 are captured into a shadow src_ip;
  - IP checksum is not checked.
- State UDP, 8 bytes:
  - bytes 0-1 go to shadow src_port;
  - bytes 2-3 must equal LOCAL_PORT;
  - bytes 4-5 give udp_len, which must be >=8, else DRAIN and drop.
  - Payload length = udp_len-8. If 0, go directly to WAIT_END with no pl_valid.
- State PAY: emit payload bytes with pl_valid=1. The first byte has pl_sof; byte (udp_len-9) has pl_eof. A single-byte payload has sof and eof on the same cycle. Then go to WAIT_END. Trailing pad/FCS bytes are never emitted.
- State WAIT_END: wait for rx_dv=0. Then pulse frm_done:
  - frm_ok=1 when no rx_er was seen since SFD and the payload completed;
  - when frm_ok=1, update src_ip/src_port from the shadows and increment frm_cnt;
  - otherwise increment drop_cnt.
- Truncation: rx_dv falls in PAY before pl_eof. pl_eof is never emitted; frm_done=1, frm_ok=0; drop_cnt increments.
- State DRAIN: ignore bytes until rx_dv=0, then go to IDLE. No frm_done.
- rx_dv low in ETH/IP/UDP: back to IDLE and increment drop_cnt. rx_dv low in PRE: back to IDLE, no count.
- Back-to-back frames: a new rx_dv after a single low cycle must be accepted.
- Counters stick at all-ones.

Optional Feature:
- Macro: ETH_RX_FCS_CHECK_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init FFFFFFFF) runs over every byte from the first MAC byte through the last FCS byte;
  - at rx_dv fall, the residue must equal 0xC704DD7B, else frm_ok=0.
  - frm_done timing is unchanged.
- Not defined: no CRC logic; FCS bytes are ignored.

Test Plan:
- Good frame: MAC 00:11:22:33:44:55, IP C0A8010A, port 0x1388, udp_len 12, payload DE AD BE EF.
  -> pl_valid 4 cycles with sof on DE, eof on EF; frm_done with frm_ok=1; frm_cnt=1; src_ip/src_port equal the sender's values.
- Broadcast MAC, correct IP/port -> accepted. Same frame with MAC 00:11:22:33:44:56 -> no pl_valid, no frm_done, drop_cnt+1.
- udp_len 8 -> no pl_valid, frm_ok=1. udp_len 5 -> drop_cnt+1. 46-byte min frame with 1-byte payload -> sof=eof on one cycle; pad bytes not emitted.
- rx_er pulse during payload byte 2 -> all 4 bytes still emitted, frm_ok=0, drop_cnt+1. rx_dv dropped after payload byte 2 -> no eof, frm_ok=0.
- reset_n low mid-payload -> all outputs 0 immediately. Next good frame after release -> accepted normally. Two good frames with 1-cycle gap -> frm_cnt=2.
- With ETH_RX_FCS_CHECK_EN: correct FCS -> frm_ok=1; one FCS bit flipped -> frm_ok=0, drop_cnt+1.
